// File: rtl/pwl_gatekeeper_mc.sv
`default_nettype none
// ============================================================================
//  Module   : pwl_gatekeeper_mc
//  Brief    : Multi-channel clocked PWL gatekeeper: (value, slope) tracking that
//             resyncs on |error| >= ETOL, with limit-cycle detection and hold.
//  Revision : 1.0 - initial release
// ============================================================================
module pwl_gatekeeper_mc #(
    parameter int NCH      = 4,
    parameter int W        = 16,
    parameter int ETOL     = 4,
    parameter int WIN      = 16,
    parameter int LC_MAX   = 4,
    parameter int HOLD_CYC = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [NCH*W-1:0] in_v,
    input  logic [NCH*W-1:0] in_s,
    output logic [NCH*W-1:0] out_v,
    output logic [NCH*W-1:0] out_s,
    output logic [NCH-1:0]   out_upd,
    output logic [NCH-1:0]   lc_flag
);

    localparam int c_win_w  = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int c_cnt_w  = $clog2(LC_MAX + 1);
    localparam int c_hold_w = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [c_win_w-1:0]  c_win_last  = c_win_w'(WIN - 1);
    localparam logic [c_cnt_w-1:0]  c_lc_max    = c_cnt_w'(LC_MAX);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYC - 1);
    localparam logic [W:0]          c_etol      = (W+1)'(ETOL);

    typedef enum logic [0:0] {
        ST_TRACK = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Clamp a W+1 bit two's-complement sum back into W bits.
    function automatic logic [W-1:0] sat(input logic [W:0] a);
        if (a[W] != a[W-1])
            return a[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return a[W-1:0];
    endfunction

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        state_t              r_state;
        logic [W-1:0]        r_v;
        logic [W-1:0]        r_s;
        logic                r_upd;
        logic                r_lc;
        logic [c_win_w-1:0]  r_win;
        logic [c_cnt_w-1:0]  r_cnt;
        logic [c_hold_w-1:0] r_hold;

        logic [W-1:0]        w_in_v;
        logic [W-1:0]        w_in_s;
        logic [W:0]          w_diff;
        logic [W:0]          w_err;
        logic [W-1:0]        w_sat_in;
        logic [W-1:0]        w_sat_int;
        logic                w_hit;
        logic                w_wrap;
        logic                w_trip;
        logic [c_cnt_w-1:0]  w_cnt_base;

        assign w_in_v     = in_v[k*W +: W];
        assign w_in_s     = in_s[k*W +: W];
        assign w_diff     = {r_v[W-1], r_v} - {w_in_v[W-1], w_in_v};
        assign w_err      = w_diff[W] ? (~w_diff + 1'b1) : w_diff;
        assign w_hit      = (w_err >= c_etol);
        assign w_sat_in   = sat({w_in_v[W-1], w_in_v} + {w_in_s[W-1], w_in_s});
        assign w_sat_int  = sat({r_v[W-1], r_v} + {r_s[W-1], r_s});
        assign w_wrap     = (r_win == c_win_last);
        // An update landing on the wrap cycle starts the new window at 1.
        assign w_cnt_base = w_wrap ? '0 : r_cnt;
        assign w_trip     = w_hit && ((w_cnt_base + 1'b1) == c_lc_max);

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_state <= ST_TRACK;
                r_v     <= '0;
                r_s     <= '0;
                r_upd   <= 1'b0;
                r_lc    <= 1'b0;
                r_win   <= '0;
                r_cnt   <= '0;
                r_hold  <= '0;
            end else if (!en) begin
                r_upd <= 1'b0;
            end else begin
                case (r_state)
                    ST_TRACK: begin
                        r_win <= w_wrap ? '0 : r_win + 1'b1;
                        if (w_hit) begin
                            r_v   <= w_sat_in;
                            r_s   <= w_trip ? '0 : w_in_s;
                            r_upd <= 1'b1;
                            r_cnt <= w_cnt_base + 1'b1;
                            if (w_trip) begin
                                r_state <= ST_HOLD;
                                r_lc    <= 1'b1;
                                r_hold  <= c_hold_last;
                            end
                        end else begin
                            r_v   <= w_sat_int;
                            r_upd <= 1'b0;
                            r_cnt <= w_cnt_base;
                        end
                    end
                    default: begin
                        r_upd <= 1'b0;
                        if (r_hold == '0) begin
                            r_state <= ST_TRACK;
                            r_lc    <= 1'b0;
                            r_cnt   <= '0;
                            r_win   <= '0;
                        end else begin
                            r_hold <= r_hold - 1'b1;
                        end
                    end
                endcase
            end
        end

        assign out_v[k*W +: W] = r_v;
        assign out_s[k*W +: W] = r_s;
        assign out_upd[k]      = r_upd;
        assign lc_flag[k]      = r_lc;
    end

endmodule
`default_nettype wire

// File: tb/tb_pwl_gatekeeper_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwl_gatekeeper_mc
//  Brief    : Directed and randomized bench for pwl_gatekeeper_mc against a
//             behavioural per-channel model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwl_gatekeeper_mc;

    localparam int NCH      = 4;
    localparam int W        = 16;
    localparam int ETOL     = 4;
    localparam int WIN      = 16;
    localparam int LC_MAX   = 4;
    localparam int HOLD_CYC = 32;
    localparam int VMAX     = (1 << (W-1)) - 1;
    localparam int VMIN     = -(1 << (W-1));

    logic             clk = 1'b0;
    logic             rstn;
    logic             en;
    logic [NCH*W-1:0] in_v;
    logic [NCH*W-1:0] in_s;
    logic [NCH*W-1:0] out_v;
    logic [NCH*W-1:0] out_s;
    logic [NCH-1:0]   out_upd;
    logic [NCH-1:0]   lc_flag;

    int total = 0;
    int bad   = 0;

    int iv [NCH];
    int is_[NCH];
    int mv [NCH];
    int ms [NCH];
    int mwin [NCH];
    int mcnt [NCH];
    int mhold[NCH];
    bit mupd [NCH];
    bit mhld [NCH];

    pwl_gatekeeper_mc #(
        .NCH(NCH), .W(W), .ETOL(ETOL), .WIN(WIN), .LC_MAX(LC_MAX), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .en     (en),
        .in_v   (in_v),
        .in_s   (in_s),
        .out_v  (out_v),
        .out_s  (out_s),
        .out_upd(out_upd),
        .lc_flag(lc_flag)
    );

    always #5 clk = ~clk;

    function automatic int sat(input int a);
        if (a > VMAX) return VMAX;
        if (a < VMIN) return VMIN;
        return a;
    endfunction

    function automatic int ov(input int k);
        return int'($signed(out_v[k*W +: W]));
    endfunction

    function automatic int os(input int k);
        return int'($signed(out_s[k*W +: W]));
    endfunction

    task automatic chk(input string tag, input logic [NCH*W-1:0] obs, input logic [NCH*W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NCH; k++) begin
            in_v[k*W +: W] = W'(iv[k]);
            in_s[k*W +: W] = W'(is_[k]);
        end
    endtask

    task automatic zero_inputs();
        for (int k = 0; k < NCH; k++) begin
            iv[k]  = 0;
            is_[k] = 0;
        end
        drive();
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            mv[k] = 0; ms[k] = 0; mwin[k] = 0; mcnt[k] = 0;
            mhold[k] = 0; mupd[k] = 0; mhld[k] = 0;
        end
    endtask

    // One clock edge of the reference behaviour, applied to every channel.
    task automatic model_step();
        int e;
        for (int k = 0; k < NCH; k++) begin
            mupd[k] = 0;
            if (en) begin
                if (mhld[k]) begin
                    if (mhold[k] == 0) begin
                        mhld[k] = 0; mcnt[k] = 0; mwin[k] = 0;
                    end else begin
                        mhold[k]--;
                    end
                end else begin
                    if (mwin[k] == WIN-1) begin
                        mwin[k] = 0; mcnt[k] = 0;
                    end else begin
                        mwin[k]++;
                    end
                    e = mv[k] - iv[k];
                    if (e < 0) e = -e;
                    if (e >= ETOL) begin
                        mcnt[k]++;
                        mv[k]   = sat(iv[k] + is_[k]);
                        mupd[k] = 1;
                        if (mcnt[k] == LC_MAX) begin
                            ms[k] = 0; mhld[k] = 1; mhold[k] = HOLD_CYC-1;
                        end else begin
                            ms[k] = is_[k];
                        end
                    end else begin
                        mv[k] = sat(mv[k] + ms[k]);
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [NCH*W-1:0] ev, es;
        logic [NCH*W-1:0] eu, el;
        ev = '0; es = '0; eu = '0; el = '0;
        for (int k = 0; k < NCH; k++) begin
            ev[k*W +: W] = W'(mv[k]);
            es[k*W +: W] = W'(ms[k]);
            eu[k] = mupd[k];
            el[k] = mhld[k];
        end
        chk({tag, ".out_v"},   out_v,   ev);
        chk({tag, ".out_s"},   out_s,   es);
        chk({tag, ".out_upd"}, {{(NCH*W-NCH){1'b0}}, out_upd}, eu);
        chk({tag, ".lc_flag"}, {{(NCH*W-NCH){1'b0}}, lc_flag}, el);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset asserted between edges, released on the next negedge.
    task automatic do_reset();
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int npulse, quiet, first, trip, lc_n, hold_upd, resume, lc_frz, fz;
        rstn = 1'b0;
        en   = 1'b1;
        zero_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("rst_init");
        @(negedge clk);
        rstn = 1'b1;

        // Reset mid-operation, then the first edge after release resyncs ch0.
        iv[0] = 500; is_[0] = 3; drive();
        repeat (3) tick("t1_run");
        do_reset();
        tick("t1_release");
        chk_int("t1_v",   ov(0), 503);
        chk_int("t1_s",   os(0), 3);
        chk_int("t1_upd", int'(out_upd[0]), 1);

        // Ramp tracking: one resync, then pure integration.
        do_reset(); zero_inputs();
        npulse = 0; quiet = 0;
        for (int k = 0; k < 100; k++) begin
            iv[0] = 100 + 2*k; is_[0] = 2; drive();
            tick("t2_ramp");
            if (out_upd[0]) npulse++;
            if (out_upd[NCH-1:1] != '0) quiet++;
        end
        chk_int("t2_pulses", npulse, 1);
        chk_int("t2_final",  ov(0), 300);
        chk_int("t2_others", quiet, 0);

        // Slope mismatch: error grows by one per edge, update at err == ETOL.
        do_reset(); zero_inputs();
        iv[0] = 1000; is_[0] = 2; drive();
        tick("t3_sync");
        first = -1;
        for (int j = 1; j <= 8; j++) begin
            iv[0] = 1002 + 3*(j-1); is_[0] = 3; drive();
            tick("t3_mismatch");
            if (out_upd[0] && first < 0) first = j;
        end
        chk_int("t3_first_upd", first, 5);

        // Limit cycle on ch1.
        do_reset(); zero_inputs();
        trip = -1; lc_n = 0; hold_upd = 0; resume = 0;
        for (int t = 0; t < 37; t++) begin
            iv[1] = (t % 2 == 0) ? 10 : 0; drive();
            tick("t4_lc");
            if (lc_flag[1]) begin
                lc_n++;
                if (trip < 0) trip = t;
                if (t > 3 && out_upd[1]) hold_upd++;
            end
            if (t == 3) chk_int("t4_trip_s", os(1), 0);
            if (t == 36) resume = int'(out_upd[1]);
        end
        chk_int("t4_trip_edge", trip, 3);
        chk_int("t4_lc_len",    lc_n, HOLD_CYC);
        chk_int("t4_hold_upd",  hold_upd, 0);
        chk_int("t4_resume",    resume, 1);

        // Saturation on ch2.
        do_reset(); zero_inputs();
        iv[2] = 32660; is_[2] = 100; drive(); tick("t5_sync");
        chk_int("t5_synced", ov(2), 32760);
        iv[2] = 32760; drive(); tick("t5_int");
        iv[2] = 32767; drive();
        repeat (5) tick("t5_sat");
        chk_int("t5_clamp", ov(2), 32767);

        // Window wrap coincides with the 4th update on ch3.
        do_reset(); zero_inputs();
        for (int t = 0; t < 19; t++) begin
            iv[3] = (t < 12) ? 0 : ((t % 2 == 0) ? 10 : 0); drive();
            tick("t5_wrap");
            if (t == 15) begin
                chk_int("t5_wrap_upd", int'(out_upd[3]), 1);
                chk_int("t5_wrap_lc",  int'(lc_flag[3]), 0);
            end
            if (t == 18) chk_int("t5_late_trip", int'(lc_flag[3]), 1);
        end

        // Freeze mid-ramp.
        do_reset(); zero_inputs();
        for (int k = 0; k < 5; k++) begin
            iv[0] = 100 + 2*k; is_[0] = 2; drive(); tick("t6_ramp");
        end
        fz = ov(0);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            iv[0] = int'($urandom_range(0, 2000)); drive(); tick("t6_frozen");
        end
        chk_int("t6_frozen_v", ov(0), 110);
        chk_int("t6_frozen_same", ov(0), fz);
        en = 1'b1;
        npulse = 0;
        for (int k = 5; k < 15; k++) begin
            iv[0] = 100 + 2*k; is_[0] = 2; drive(); tick("t6_resume");
            if (out_upd[0]) npulse++;
        end
        chk_int("t6_resume_pulses", npulse, 0);
        chk_int("t6_resume_v", ov(0), 130);

        // Freeze during HOLD: enabled high time is still HOLD_CYC.
        do_reset(); zero_inputs();
        lc_n = 0; lc_frz = 0;
        for (int t = 0; t < 46; t++) begin
            en = !(t >= 10 && t < 20);
            iv[1] = (t % 2 == 0) ? 10 : 0; drive();
            tick("t6_hold_frz");
            if (lc_flag[1]) begin
                if (en) lc_n++;
                else lc_frz++;
            end
        end
        en = 1'b1;
        chk_int("t6_hold_len", lc_n, HOLD_CYC);
        chk_int("t6_hold_frz_n", lc_frz, 10);
        chk_int("t6_hold_exit", int'(lc_flag[1]), 0);

        // Reset while in HOLD.
        do_reset(); zero_inputs();
        for (int t = 0; t < 9; t++) begin
            iv[1] = (t % 2 == 0) ? 10 : 0; drive(); tick("t6_enter");
        end
        chk_int("t6_in_hold", int'(lc_flag[1]), 1);
        do_reset();
        chk_int("t6_rst_lc", int'(lc_flag[1]), 0);
        iv[1] = 10; drive(); tick("t6_after_rst");
        chk_int("t6_after_rst_upd", int'(out_upd[1]), 1);

        // Randomized traffic on all channels.
        do_reset(); zero_inputs();
        for (int n = 0; n < 600; n++) begin
            en = ($urandom_range(0, 9) != 0);
            for (int k = 0; k < NCH; k++) begin
                case ($urandom_range(0, 19))
                    0:       iv[k] = int'($urandom_range(0, 65535)) + VMIN;
                    1:       iv[k] = VMAX - int'($urandom_range(0, 50));
                    default: iv[k] = sat(iv[k] + int'($urandom_range(0, 8)) - 4);
                endcase
                is_[k] = int'($urandom_range(0, 6)) - 3;
            end
            drive();
            tick("rand");
            if ($urandom_range(0, 249) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
